// File: rtl/bp_pkg.sv
// Shared types, table constants and the 2-bit counter update rule for the
// fetch-stage branch predictor.
package bp_pkg;

  localparam int INDEX_W_DEF = 6;
  localparam int TAG_W_DEF   = 30 - INDEX_W_DEF;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // One BTB entry at the default geometry; target keeps pc[31:2] only.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [29:0]          target;
    ctr_t                 ctr;
  } btb_entry_t;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic ctr_t sat_ctr_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : c + 2'd1;
    end
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  // Count one event per enabled edge, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count <= '0;
    end else if (i_inc && (o_count != 32'hFFFF_FFFF)) begin
      o_count <= o_count + 32'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped BTB with 2-bit counters. Predicts from registered
// table state with no bypass, trains from the execute-stage resolution, flags
// mispredicts with the corrected next PC and keeps saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         INDEX_W  = INDEX_W_DEF,
  parameter int         TAG_W    = TAG_W_DEF,
  parameter logic [1:0] CNT_INIT = WT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        r_valid,
  input  logic [31:0] r_pc,
  input  logic        r_branch,
  input  logic        r_jump,
  input  logic        r_jalr,
  input  logic        r_taken,
  input  logic [31:0] r_target,
  input  logic        r_pred_taken,
  input  logic [31:0] r_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Control state (valid, counter) is reset; tag/target are plain data.
  logic               r_vld [ENTRIES];
  ctr_t               r_ctr [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [29:0]        r_tgt [ENTRIES];

  logic [INDEX_W-1:0] w_f_idx;
  logic [TAG_W-1:0]   w_f_tag;
  logic [INDEX_W-1:0] w_r_idx;
  logic [TAG_W-1:0]   w_r_tag;
  logic               w_r_hit;
  logic               w_is_ctl;
  logic               w_train;
  logic [31:0]        w_actual_next;
  logic               w_unused;

  assign w_f_idx = f_pc[INDEX_W+1:2];
  assign w_f_tag = f_pc[31:INDEX_W+2];
  assign w_r_idx = r_pc[INDEX_W+1:2];
  assign w_r_tag = r_pc[31:INDEX_W+2];

  // The carried prediction bit is redundant with the carried target.
  assign w_unused = r_pred_taken;

  // Fetch-side lookup: zero-latency read of the pre-edge table contents.
  always_comb begin
    pred_hit    = f_valid & r_vld[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);
    pred_taken  = pred_hit & r_ctr[w_f_idx][1];
    pred_target = pred_taken ? {r_tgt[w_f_idx], 2'b00} : (f_pc + 32'd4);
  end

  // Resolution compare: only real control flow can raise a mispredict.
  always_comb begin
    w_is_ctl      = r_branch | r_jump | r_jalr;
    w_actual_next = r_taken ? r_target : (r_pc + 32'd4);
    mispredict    = r_valid & w_is_ctl & (w_actual_next != r_pred_target);
    redirect_pc   = r_valid ? w_actual_next : 32'd0;
  end

  // Indirect jumps have no stable target, so they never touch the table.
  assign w_train = r_valid & (r_branch | r_jump) & ~r_jalr;
  assign w_r_hit = r_vld[w_r_idx] & (r_tag[w_r_idx] == w_r_tag);

  // Train counters on a hit, allocate on a taken miss; reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_ctr[i] <= WNT;
      end
    end else if (w_train) begin
      if (w_r_hit) begin
        r_ctr[w_r_idx] <= sat_ctr_next(r_ctr[w_r_idx], r_taken);
      end else if (r_taken) begin
        r_vld[w_r_idx] <= 1'b1;
        r_ctr[w_r_idx] <= CNT_INIT;
      end
    end
  end

  // Tag/target capture on any trained taken outcome (hit refresh or alloc).
  always_ff @(posedge clk) begin
    if (w_train && r_taken) begin
      r_tag[w_r_idx] <= w_r_tag;
      r_tgt[w_r_idx] <= r_target[31:2];
    end
  end

  bp_sat_counter32 u_stat_branches (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (r_valid & w_is_ctl),
    .o_count (stat_branches)
  );

  bp_sat_counter32 u_stat_mispred (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (mispredict),
    .o_count (stat_mispred)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, async reset sequences
// and randomized traffic checked against a behavioural table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_branch;
  logic        r_jump;
  logic        r_jalr;
  logic        r_taken;
  logic [31:0] r_target;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .r_valid       (r_valid),
    .r_pc          (r_pc),
    .r_branch      (r_branch),
    .r_jump        (r_jump),
    .r_jalr        (r_jalr),
    .r_taken       (r_taken),
    .r_target      (r_target),
    .r_pred_taken  (r_pred_taken),
    .r_pred_target (r_pred_target),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  // ---------------- behavioural model ----------------
  localparam int NENT = 64;
  bit          m_val [NENT];
  longint      m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  int          m_ctr [NENT];
  longint      m_br;
  longint      m_mp;
  localparam longint SATMAX = 64'h0000_0000_FFFF_FFFF;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % NENT);
  endfunction

  function automatic longint tag_of(input logic [31:0] pc);
    return longint'(pc) / (4 * NENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_val[i] = 0;
      m_ctr[i] = 1;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  function automatic void model_pred(input logic fv, input logic [31:0] pc,
                                     output logic hit, output logic tk,
                                     output logic [31:0] tgt);
    int i;
    i   = idx_of(pc);
    hit = fv && m_val[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_res(output logic mp, output logic [31:0] rdr);
    logic [31:0] nxt;
    nxt = r_taken ? r_target : r_pc + 32'd4;
    mp  = r_valid && (r_branch || r_jump || r_jalr) && (nxt != r_pred_target);
    rdr = r_valid ? nxt : 32'd0;
  endfunction

  // Applies the effect of one clock edge with rst_n high.
  task automatic model_edge();
    logic mp;
    logic [31:0] rdr;
    int i;
    bit hit;
    model_res(mp, rdr);
    if (r_valid && (r_branch || r_jump || r_jalr)) begin
      if (m_br < SATMAX) m_br++;
      if (mp && m_mp < SATMAX) m_mp++;
    end
    if (r_valid && (r_branch || r_jump) && !r_jalr) begin
      i   = idx_of(r_pc);
      hit = m_val[i] && (m_tag[i] == tag_of(r_pc));
      if (hit) begin
        m_ctr[i] = r_taken ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                           : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
        if (r_taken) m_tgt[i] = r_target & 32'hFFFF_FFFC;
      end else if (r_taken) begin
        m_val[i] = 1;
        m_tag[i] = tag_of(r_pc);
        m_tgt[i] = r_target & 32'hFFFF_FFFC;
        m_ctr[i] = 2;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic chk_model(input string nm);
    logic hit, tk, mp;
    logic [31:0] tgt, rdr;
    model_pred(f_valid, f_pc, hit, tk, tgt);
    model_res(mp, rdr);
    chk({nm, ".pred_hit"},    {31'd0, pred_hit},   {31'd0, hit});
    chk({nm, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({nm, ".pred_target"}, pred_target, tgt);
    chk({nm, ".mispredict"},  {31'd0, mispredict}, {31'd0, mp});
    chk({nm, ".redirect_pc"}, redirect_pc, rdr);
    chk({nm, ".stat_br"},     stat_branches, m_br[31:0]);
    chk({nm, ".stat_mp"},     stat_mispred,  m_mp[31:0]);
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] rpc;
    logic        br, jmp, jalr, tkn;
    logic [31:0] rtgt, rpt;
    logic        e_hit, e_tk;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [31:0] e_rdr;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic fv, input logic [31:0] fpc,
                              input logic rv, input logic [31:0] rpc,
                              input logic br, input logic jmp, input logic jalr,
                              input logic tkn, input logic [31:0] rtgt,
                              input logic [31:0] rpt, input logic e_hit,
                              input logic e_tk, input logic [31:0] e_tgt,
                              input logic e_mp, input logic [31:0] e_rdr);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.rv = rv; v.rpc = rpc;
    v.br = br; v.jmp = jmp; v.jalr = jalr; v.tkn = tkn;
    v.rtgt = rtgt; v.rpt = rpt;
    v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt;
    v.e_mp = e_mp; v.e_rdr = e_rdr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    f_valid = v.fv; f_pc = v.fpc; r_valid = v.rv; r_pc = v.rpc;
    r_branch = v.br; r_jump = v.jmp; r_jalr = v.jalr; r_taken = v.tkn;
    r_target = v.rtgt; r_pred_target = v.rpt; r_pred_taken = 1'b0;
  endtask

  initial begin
    //            fv fpc           rv rpc        br jp jr tk rtgt          rpt           hit tk tgt           mp rdr
    tbl[0]  = mk(1, 32'h100,      0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h104,      0, 32'h0);
    tbl[1]  = mk(1, 32'h100,      1, 32'h100,   1, 0, 0, 1, 32'h40,       32'h104,      0, 0, 32'h104,      1, 32'h40);
    tbl[2]  = mk(1, 32'h100,      1, 32'h100,   1, 0, 0, 1, 32'h40,       32'h40,       1, 1, 32'h40,       0, 32'h40);
    tbl[3]  = mk(1, 32'h100,      1, 32'h100,   1, 0, 0, 1, 32'h40,       32'h40,       1, 1, 32'h40,       0, 32'h40);
    tbl[4]  = mk(1, 32'h100,      1, 32'h100,   1, 0, 0, 1, 32'h40,       32'h40,       1, 1, 32'h40,       0, 32'h40);
    tbl[5]  = mk(1, 32'h100,      1, 32'h100,   1, 0, 0, 0, 32'h40,       32'h40,       1, 1, 32'h40,       1, 32'h104);
    tbl[6]  = mk(1, 32'h100,      0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h40,       0, 32'h0);
    tbl[7]  = mk(1, 32'h200,      1, 32'h200,   1, 0, 0, 1, 32'h80,       32'h204,      0, 0, 32'h204,      1, 32'h80);
    tbl[8]  = mk(1, 32'h100,      0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h104,      0, 32'h0);
    tbl[9]  = mk(1, 32'h200,      0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h80,       0, 32'h0);
    tbl[10] = mk(1, 32'h300,      1, 32'h300,   0, 0, 1, 1, 32'h500,      32'h304,      0, 0, 32'h304,      1, 32'h500);
    tbl[11] = mk(1, 32'h300,      0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h304,      0, 32'h0);
    tbl[12] = mk(1, 32'h200,      1, 32'h200,   1, 0, 0, 0, 32'h80,       32'h80,       1, 1, 32'h80,       1, 32'h204);
    tbl[13] = mk(1, 32'h200,      0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h204,      0, 32'h0);
    tbl[14] = mk(0, 32'h200,      1, 32'h400,   0, 0, 0, 1, 32'h600,      32'h0,        0, 0, 32'h204,      0, 32'h600);
    tbl[15] = mk(1, 32'hFFFFFFFC, 0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0);

    // Reset state
    rst_n = 1'b0;
    drive(tbl[0]);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.pred_hit",    {31'd0, pred_hit},   32'd0);
    chk("rst.pred_taken",  {31'd0, pred_taken}, 32'd0);
    chk("rst.pred_target", pred_target,         32'h104);
    chk("rst.mispredict",  {31'd0, mispredict}, 32'd0);
    chk("rst.stat_br",     stat_branches,       32'd0);
    chk("rst.stat_mp",     stat_mispred,        32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d.pred_hit", i),    {31'd0, pred_hit},   {31'd0, tbl[i].e_hit});
      chk($sformatf("vec%0d.pred_taken", i),  {31'd0, pred_taken}, {31'd0, tbl[i].e_tk});
      chk($sformatf("vec%0d.pred_target", i), pred_target,         tbl[i].e_tgt);
      chk($sformatf("vec%0d.mispredict", i),  {31'd0, mispredict}, {31'd0, tbl[i].e_mp});
      chk($sformatf("vec%0d.redirect_pc", i), redirect_pc,         tbl[i].e_rdr);
      chk($sformatf("vec%0d.stat_br", i),     stat_branches,       m_br[31:0]);
      tick();
    end
    @(negedge clk);
    chk("tbl.stat_br_total", stat_branches, 32'd8);
    chk("tbl.stat_mp_total", stat_mispred,  32'd5);

    // Async reset mid-stream: entries miss immediately, stats cleared
    drive(mk(1, 32'h200, 1, 32'h200, 1, 0, 0, 1, 32'h80, 32'h80, 0, 0, 0, 0, 0));
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.pred_hit",    {31'd0, pred_hit}, 32'd0);
    chk("midrst.pred_target", pred_target,       32'h204);
    chk("midrst.stat_br",     stat_branches,     32'd0);
    tick();
    #1;
    rst_n = 1'b1;
    drive(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("postrst.pred_hit", {31'd0, pred_hit}, 32'd0);
    chk("postrst.stat_mp",  stat_mispred,      32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic hit, tk;
      logic [31:0] tgt;
      int cls;
      f_valid = ($urandom_range(0, 7) != 0);
      f_pc    = ($urandom_range(0, 15) == 0) ? $urandom()
              : {21'd0, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      r_valid = ($urandom_range(0, 4) != 0);
      r_pc    = ($urandom_range(0, 15) == 0) ? $urandom()
              : {21'd0, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 3)), 2'b00};
      cls      = $urandom_range(0, 4);
      r_branch = (cls == 0) || (cls == 1);
      r_jump   = (cls == 2);
      r_jalr   = (cls == 3);
      r_taken  = (r_jump || r_jalr) ? 1'b1 : 1'($urandom_range(0, 1));
      r_target = ($urandom_range(0, 3) == 0) ? $urandom() : {20'd0, 10'($urandom_range(0, 63)), 2'b00};
      model_pred(1'b1, r_pc, hit, tk, tgt);
      r_pred_taken  = tk;
      r_pred_target = ($urandom_range(0, 2) != 0) ? tgt : $urandom();
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
      end
      @(negedge clk);
      chk_model($sformatf("rnd%0d", n));
      tick();
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage predictor for the 6-stage core. Pairs with the execute-stage branch resolver.
- Each cycle it predicts taken/not-taken and a target for the fetch PC, using a direct-mapped BTB with 2-bit saturating counters.
- It consumes the execute-stage resolution (taken, target, instruction class), trains the tables, and flags mispredicts with the corrected redirect PC.
- It also keeps saturating statistics counters for branches and mispredicts.

Parameters:
- INDEX_W, 6, log2 of table entries (64 entries)
- TAG_W, 24, tag width; must equal 30-INDEX_W
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_valid  in  1  fetch PC valid this cycle
- f_pc  in  32  fetch PC
- pred_hit  out  1  BTB tag match for f_pc
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC (f_pc+4 when not taken)
- r_valid  in  1  resolve info valid (execute stage, not flushed)
- r_pc  in  32  PC of resolving instruction
- r_branch  in  1  conditional branch
- r_jump  in  1  jal
- r_jalr  in  1  jalr
- r_taken  in  1  actual outcome (resolver Btaken | jump | jalr)
- r_target  in  32  actual taken target
- r_pred_taken  in  1  prediction carried down the pipe
- r_pred_target  in  32  predicted next PC carried down the pipe
- mispredict  out  1  flush/redirect request
- redirect_pc  out  32  correct next PC
- stat_branches  out  32  resolved control-flow instruction count
- stat_mispred  out  32  mispredict count

Behaviour:
- Index = pc[INDEX_W+1:2]. Tag = pc[31:INDEX_W+2]. pc[1:0] ignored.
- Each entry holds: valid, tag, target[31:2], ctr[1:0]. Entries are flop arrays.
- Reset (async, rst_n=0):
  - all valid=0, all ctr=2'b01;
  - stat counters=0;
  - outputs then read pred_hit=0, pred_taken=0, pred_target=f_pc+4, mispredict=0.
- Prediction is combinational from registered table state with zero latency:
  - pred_hit = f_valid & valid[idx] & tag match;
  - pred_taken = pred_hit & ctr[1];
  - pred_target = pred_taken ? {target,2'b00} : f_pc+4 (32-bit wrap; 0xFFFFFFFC+4=0).
- Resolution, combinational; all zero when r_valid=0:
  - actual_next = r_taken ? r_target : r_pc+4;
  - mispredict = r_valid & (r_branch|r_jump|r_jalr) & (actual_next != r_pred_target);
  - redirect_pc = actual_next.
- Non-control instructions (all class bits 0) never mispredict and never train.
- Update happens on the clk edge when r_valid & (r_branch|r_jump):
  - Hit at r_pc: ctr saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00). Target overwritten when taken.
  - Miss and taken: allocate (valid=1, tag, target, ctr=CNT_INIT), replacing any occupant.
  - Miss and not taken: no change.
- r_jalr never allocates or trains (indirect); it is still counted and checked for mispredict.
- Simultaneous read of f_pc and write of r_pc to the same index: prediction uses the pre-edge value (no bypass). The update is visible the cycle after the edge.
- Stats on each edge with r_valid & (r_branch|r_jump|r_jalr):
  - stat_branches += 1;
  - stat_mispred += mispredict;
  - both saturate at 0xFFFFFFFF.
- Reset mid-operation: table and stats cleared immediately. No partial update is committed on the edge coinciding with rst_n low.

Decomposition:
- Shared package bp_pkg holds:
  - INDEX_W/TAG_W defaults;
  - typedef btb_entry_t {valid, tag, target, ctr};
  - ctr constants SNT=00, WNT=01, WT=10, ST=11;
  - function sat_ctr_next(ctr, taken).
- One sub-module, bp_sat_counter32, serves as the saturating statistics counter (instantiated twice).

Test Plan:
- Reset, then f_valid=1, f_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104. Stats read 0.
- Resolve beq at r_pc=0x100, r_taken=1, r_target=0x40, r_pred_target=0x104 → mispredict=1, redirect_pc=0x40. Next cycle f_pc=0x100 gives pred_hit=1, pred_taken=1, pred_target=0x40.
- Train 0x100 taken 3 more times (ctr 11), then not taken once → ctr=10, still predicts taken. Mispredict=1 with redirect_pc=0x104 on that not-taken resolve.
- Aliasing: allocate 0x100, then taken branch at 0x200 (same index with INDEX_W=6) → 0x100 now pred_hit=0, 0x200 hits.
- jalr at 0x300, r_target=0x500, r_pred_target=0x304 → mispredict=1, redirect_pc=0x500. No allocation (0x300 pred_hit=0 afterwards). stat_branches increments.
- Same-cycle f_pc=0x100 and resolve update at 0x100 → prediction shows old ctr; new ctr visible next cycle. Assert rst_n=0 mid-stream → all entries miss immediately.
